// File: rtl/sgpr_pkg.sv
// Shared types and sizing helpers for the lockstep GPR write-back controller.
package sgpr_pkg;

    localparam int unsigned SGPR_DW       = 32;
    localparam int unsigned DEF_MAX_SKEW  = 4;
    localparam int unsigned DEF_MAX_RETRY = 3;

    function automatic int unsigned cnt_w(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

    localparam int unsigned SKEW_CNT_W  = cnt_w(DEF_MAX_SKEW);
    localparam int unsigned RETRY_CNT_W = cnt_w(DEF_MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_A,
        WAIT_B,
        COMPARE,
        RECOVER,
        FATAL
    } ctrl_state_e;

    // The data field width is fixed to SGPR_DW; instantiate the controller with DATA_WIDTH == SGPR_DW.
    typedef struct packed {
        logic [4:0]         addr;
        logic [SGPR_DW-1:0] data;
    } sgpr_wr_t;

endpackage

// File: rtl/sgpr_commit_ctrl_if.sv
// Core-pair write ports plus shared-GPR commit and recovery signalling.
interface sgpr_commit_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_W      = 8
);
    logic                  we_a_i;
    logic [4:0]            addr_a_i;
    logic [DATA_WIDTH-1:0] data_a_i;
    logic                  we_b_i;
    logic [4:0]            addr_b_i;
    logic [DATA_WIDTH-1:0] data_b_i;
    logic                  recover_done_i;
    logic                  stall_a_o;
    logic                  stall_b_o;
    logic                  commit_we_o;
    logic [4:0]            commit_addr_o;
    logic [DATA_WIDTH-1:0] commit_data_o;
    logic                  rollback_o;
    logic                  fatal_o;
    logic [CNT_W-1:0]      err_count_o;

    modport master (
        output we_a_i, addr_a_i, data_a_i, we_b_i, addr_b_i, data_b_i, recover_done_i,
        input  stall_a_o, stall_b_o, commit_we_o, commit_addr_o, commit_data_o,
               rollback_o, fatal_o, err_count_o
    );

    modport slave (
        input  we_a_i, addr_a_i, data_a_i, we_b_i, addr_b_i, data_b_i, recover_done_i,
        output stall_a_o, stall_b_o, commit_we_o, commit_addr_o, commit_data_o,
               rollback_o, fatal_o, err_count_o
    );
endinterface

// File: rtl/sgpr_capture.sv
// Single-side write capture slot: holds one pending GPR write until cleared.
module sgpr_capture
    import sgpr_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     load_i,
    input  logic     clr_i,
    input  sgpr_wr_t wr_i,
    output logic     valid_o,
    output sgpr_wr_t wr_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            valid_o <= 1'b0;
            wr_o    <= '0;
        end else if (load_i) begin
            valid_o <= 1'b1;
            wr_o    <= wr_i;
        end
    end

endmodule

// File: rtl/sgpr_commit_ctrl.sv
// Lockstep write-back controller: pairs core A/B GPR writes, commits matches,
// and drives rollback/replay or a sticky fatal flag on divergence.
module sgpr_commit_ctrl
    import sgpr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SGPR_DW,
    parameter int unsigned MAX_SKEW   = DEF_MAX_SKEW,
    parameter int unsigned MAX_RETRY  = DEF_MAX_RETRY,
    parameter int unsigned CNT_W      = 8
) (
    input logic              clk_i,
    input logic              rst_i,
    sgpr_commit_ctrl_if.slave bus
);

    localparam int unsigned SKEW_W  = cnt_w(MAX_SKEW);
    localparam int unsigned RETRY_W = cnt_w(MAX_RETRY);
    localparam logic [SKEW_W-1:0]  SKEW_LAST = SKEW_W'(MAX_SKEW - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

    ctrl_state_e        state_q;
    logic [SKEW_W-1:0]  skew_q;
    logic [RETRY_W-1:0] retry_q;

    sgpr_wr_t wr_a_in, wr_b_in, slot_a, slot_b;
    logic     valid_a, valid_b;
    logic     load_a, load_b, clr_slots;
    logic     arrive, timeout, match, fail;

    always_comb begin
        wr_a_in   = '{addr: bus.addr_a_i, data: bus.data_a_i};
        wr_b_in   = '{addr: bus.addr_b_i, data: bus.data_b_i};
        load_a    = bus.we_a_i && (state_q == IDLE || state_q == WAIT_A);
        load_b    = bus.we_b_i && (state_q == IDLE || state_q == WAIT_B);
        arrive    = (state_q == WAIT_A && bus.we_a_i) || (state_q == WAIT_B && bus.we_b_i);
        // An arrival in the last allowed wait cycle beats the timeout.
        timeout   = (state_q == WAIT_A || state_q == WAIT_B) && !arrive && (skew_q == SKEW_LAST);
        match     = valid_a && valid_b && (slot_a == slot_b);
        fail      = (state_q == COMPARE && !match) || timeout;
        clr_slots = (state_q == COMPARE) || (state_q == RECOVER) || timeout;
    end

    sgpr_capture u_cap_a (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (load_a),
        .clr_i   (clr_slots),
        .wr_i    (wr_a_in),
        .valid_o (valid_a),
        .wr_o    (slot_a)
    );

    sgpr_capture u_cap_b (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (load_b),
        .clr_i   (clr_slots),
        .wr_i    (wr_b_in),
        .valid_o (valid_b),
        .wr_o    (slot_b)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q           <= IDLE;
            skew_q            <= '0;
            retry_q           <= '0;
            bus.stall_a_o     <= 1'b0;
            bus.stall_b_o     <= 1'b0;
            bus.commit_we_o   <= 1'b0;
            bus.commit_addr_o <= '0;
            bus.commit_data_o <= '0;
            bus.rollback_o    <= 1'b0;
            bus.fatal_o       <= 1'b0;
            bus.err_count_o   <= '0;
        end else begin
            bus.commit_we_o <= 1'b0;
            bus.rollback_o  <= 1'b0;

            case (state_q)
                IDLE: begin
                    skew_q <= '0;
                    if (bus.we_a_i && bus.we_b_i) begin
                        state_q <= COMPARE;
                    end else if (bus.we_a_i) begin
                        state_q       <= WAIT_B;
                        bus.stall_a_o <= 1'b1;
                    end else if (bus.we_b_i) begin
                        state_q       <= WAIT_A;
                        bus.stall_b_o <= 1'b1;
                    end
                end
                WAIT_A: begin
                    if (bus.we_a_i) begin
                        state_q       <= COMPARE;
                        bus.stall_b_o <= 1'b0;
                        skew_q        <= '0;
                    end else begin
                        skew_q <= skew_q + 1'b1;
                    end
                end
                WAIT_B: begin
                    if (bus.we_b_i) begin
                        state_q       <= COMPARE;
                        bus.stall_a_o <= 1'b0;
                        skew_q        <= '0;
                    end else begin
                        skew_q <= skew_q + 1'b1;
                    end
                end
                COMPARE: begin
                    if (match) begin
                        state_q           <= IDLE;
                        retry_q           <= '0;
                        bus.commit_we_o   <= 1'b1;
                        bus.commit_addr_o <= slot_a.addr;
                        bus.commit_data_o <= slot_a.data;
                    end
                end
                RECOVER: begin
                    if (bus.recover_done_i) begin
                        state_q       <= IDLE;
                        bus.stall_a_o <= 1'b0;
                        bus.stall_b_o <= 1'b0;
                    end
                end
                FATAL: begin
                    state_q <= FATAL;
                end
                default: state_q <= IDLE;
            endcase

            // Compare mismatch and skew timeout share one escalation path.
            if (fail) begin
                skew_q        <= '0;
                retry_q       <= retry_q + 1'b1;
                bus.stall_a_o <= 1'b1;
                bus.stall_b_o <= 1'b1;
                if (bus.err_count_o != '1) begin
                    bus.err_count_o <= bus.err_count_o + 1'b1;
                end
                if (retry_q + 1'b1 == RETRY_LIM) begin
                    state_q     <= FATAL;
                    bus.fatal_o <= 1'b1;
                end else begin
                    state_q        <= RECOVER;
                    bus.rollback_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sgpr_commit_ctrl.sv
// Randomized transaction-level bench for sgpr_commit_ctrl with an outcome-based reference model.
module tb_sgpr_commit_ctrl;

    localparam int MAX_SKEW  = 4;
    localparam int MAX_RETRY = 3;
    localparam int CNT_W     = 3;
    localparam int ERR_MAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sgpr_commit_ctrl_if #(.DATA_WIDTH(32), .CNT_W(CNT_W)) bus ();

    sgpr_commit_ctrl #(
        .DATA_WIDTH (32),
        .MAX_SKEW   (MAX_SKEW),
        .MAX_RETRY  (MAX_RETRY),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    // Reference model: outcome counters plus the commit register contents.
    int          m_err, m_retry;
    bit          m_fatal, m_commit_next;
    logic [4:0]  m_caddr, m_pend_addr;
    logic [31:0] m_cdata, m_pend_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_err = 0; m_retry = 0; m_fatal = 0; m_commit_next = 0;
        m_caddr = '0; m_cdata = '0; m_pend_addr = '0; m_pend_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit wa, input logic [4:0] aa, input logic [31:0] da,
                         input bit wb, input logic [4:0] ba, input logic [31:0] db,
                         input bit rd, input bit r);
        bus.we_a_i = wa; bus.addr_a_i = aa; bus.data_a_i = da;
        bus.we_b_i = wb; bus.addr_b_i = ba; bus.data_b_i = db;
        bus.recover_done_i = rd;
        rst = r;
    endtask

    task automatic drive_noise(input bit r);
        drive(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom,
              1'($urandom), r);
    endtask

    task automatic check_cycle(input bit sa, input bit sb, input bit rb);
        bit cw;
        cw = m_commit_next;
        m_commit_next = 0;
        if (cw) begin
            m_caddr = m_pend_addr;
            m_cdata = m_pend_data;
        end
        check("stall_a", bus.stall_a_o, sa);
        check("stall_b", bus.stall_b_o, sb);
        check("commit_we", bus.commit_we_o, cw);
        check("commit_addr", bus.commit_addr_o, m_caddr);
        check("commit_data", bus.commit_data_o, m_cdata);
        check("rollback", bus.rollback_o, rb);
        check("fatal", bus.fatal_o, m_fatal);
        check("err_count", bus.err_count_o, m_err);
    endtask

    task automatic idle_cycle();
        tick();
        check_cycle(1'b0, 1'b0, 1'b0);
        drive(1'b0, 5'($urandom), $urandom, 1'b0, 5'($urandom), $urandom, 1'($urandom), 1'b0);
    endtask

    task automatic reset_cycle(input bit sa, input bit sb);
        tick();
        check_cycle(sa, sb, 1'b0);
        drive_noise(1'b1);
        model_reset();
    endtask

    // One pair: the second side arrives d cycles after the first (d > MAX_SKEW: never).
    // r = cycles spent in recovery before recover_done_i; rst_at = cycle index for a reset (-1 none).
    task automatic run_pair(input bit first_a, input int d,
                            input logic [4:0] aa, input logic [31:0] da,
                            input logic [4:0] ba, input logic [31:0] db,
                            input int r, input int rst_at);
        bit tmo, fails, to_fatal, wa, wb, rd, sa, sb, rb;
        int w, f, e;
        logic [4:0]  xa, xb;
        logic [31:0] ya, yb;
        tmo      = (d > MAX_SKEW);
        fails    = tmo || (aa !== ba) || (da !== db);
        w        = tmo ? MAX_SKEW : d;
        f        = tmo ? MAX_SKEW + 1 : d + 2;
        to_fatal = fails && (m_retry + 1 == MAX_RETRY);
        e        = !fails ? d + 1 : (to_fatal ? f + 2 : f + r);
        for (int c = 0; c <= e; c++) begin
            tick();
            if (fails && c == f) begin
                if (m_err < ERR_MAX) m_err++;
                m_retry++;
                m_fatal = to_fatal;
            end
            sa = (fails && c >= f) || (first_a && c >= 1 && c <= w);
            sb = (fails && c >= f) || (!first_a && c >= 1 && c <= w);
            rb = fails && (c == f) && !to_fatal;
            check_cycle(sa, sb, rb);
            if (c == rst_at) begin
                drive_noise(1'b1);
                model_reset();
                return;
            end
            wa = 0; wb = 0; rd = 0;
            xa = 5'($urandom); ya = $urandom; xb = 5'($urandom); yb = $urandom;
            if (c == 0) begin
                if (first_a || d == 0) begin wa = 1; xa = aa; ya = da; end
                if (!first_a || d == 0) begin wb = 1; xb = ba; yb = db; end
            end else if (c <= w) begin
                // Repeat strobes from the already-captured side must be ignored.
                if ($urandom_range(0, 3) == 0) begin
                    if (first_a) wa = 1; else wb = 1;
                end
                if (!tmo && c == d) begin
                    if (first_a) begin wb = 1; xb = ba; yb = db; end
                    else begin wa = 1; xa = aa; ya = da; end
                end
                rd = ($urandom_range(0, 7) == 0);
            end else if (fails && c >= f) begin
                wa = 1'($urandom); wb = 1'($urandom);
                rd = to_fatal ? 1'($urandom) : (c == f + r);
            end
            drive(wa, xa, ya, wb, xb, yb, rd, 1'b0);
        end
        if (!fails) begin
            m_commit_next = 1;
            m_pend_addr   = aa;
            m_pend_data   = da;
            m_retry       = 0;
        end
    endtask

    task automatic clear_fatal();
        if (m_fatal) begin
            for (int i = 0; i < 2; i++) begin
                tick();
                check_cycle(1'b1, 1'b1, 1'b0);
                drive_noise(1'b0);
            end
            reset_cycle(1'b1, 1'b1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [4:0]  a_addr, b_addr;
        logic [31:0] a_data, b_data;
        int          d, sel;

        model_reset();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        tick();
        check_cycle(1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);

        // Directed scenarios
        run_pair(1'b1, 0, 5'd5, 32'hDEADBEEF, 5'd5, 32'hDEADBEEF, 0, -1);
        idle_cycle();
        run_pair(1'b1, 2, 5'd3, 32'h11, 5'd3, 32'h11, 0, -1);
        idle_cycle();
        run_pair(1'b1, 0, 5'd7, 32'h10, 5'd7, 32'h11, 5, -1);
        idle_cycle();
        run_pair(1'b1, MAX_SKEW + 1, 5'd9, 32'h99, 5'd9, 32'h99, 1, -1);
        idle_cycle();
        run_pair(1'b0, MAX_SKEW, 5'd2, 32'hA5A5, 5'd2, 32'hA5A5, 0, -1);
        run_pair(1'b1, 0, 5'd4, 32'h1234, 5'd4, 32'h1234, 0, -1);
        reset_cycle(1'b0, 1'b0);
        for (int i = 0; i < MAX_RETRY; i++)
            run_pair(1'b1, 0, 5'd7, 32'h10, 5'd6, 32'h10, 0, -1);
        clear_fatal();
        idle_cycle();
        run_pair(1'b1, 1, 5'd12, 32'hCAFE0001, 5'd12, 32'hCAFE0001, 0, -1);
        run_pair(1'b0, 0, 5'd1, 32'h1, 5'd1, 32'h2, 0, -1);
        run_pair(1'b0, 0, 5'd1, 32'h1, 5'd1, 32'h3, 2, -1);
        run_pair(1'b1, 0, 5'd8, 32'h88, 5'd8, 32'h88, 0, -1);
        run_pair(1'b1, 0, 5'd1, 32'h1, 5'd1, 32'h4, 0, -1);
        idle_cycle();
        run_pair(1'b1, 0, 5'd7, 32'h10, 5'd7, 32'h11, 5, 3);
        idle_cycle();
        run_pair(1'b1, 0, 5'd15, 32'h0F0F, 5'd15, 32'h0F0F, 0, -1);
        idle_cycle();

        // Randomized pairs
        for (int n = 0; n < 300; n++) begin
            a_addr = 5'($urandom);
            a_data = $urandom;
            b_addr = a_addr;
            b_data = a_data;
            sel = $urandom_range(0, 7);
            if (sel == 0) b_data = b_data ^ (32'h1 << $urandom_range(0, 31));
            else if (sel == 1) b_addr = b_addr ^ (5'h1 << $urandom_range(0, 4));
            d = ($urandom_range(0, 9) == 0) ? MAX_SKEW + 1 : $urandom_range(0, MAX_SKEW);
            run_pair(1'($urandom), d, a_addr, a_data, b_addr, b_data,
                     $urandom_range(0, 4),
                     ($urandom_range(0, 29) == 0) ? $urandom_range(0, 8) : -1);
            clear_fatal();
            for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle();
        end
        idle_cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
